// File: rtl/tl_sequencer.sv
// -----------------------------------------------------------------------------
// tl_sequencer
//
// Timed next-state controller for a four-phase traffic light with left-turn
// phases. Sequences the 3-bit phase state from road sensors, dwell timing and
// latched left-turn requests, and decodes the state into per-street light codes.
//
// Ports
//   clk    in  1  clock, rising edge
//   reset  in  1  asynchronous, active-high reset
//   Ta     in  1  street A through traffic present
//   Tb     in  1  street B through traffic present
//   Tal    in  1  street A left-turn request
//   Tbl    in  1  street B left-turn request
//   q      out 3  registered phase state
//   La     out 2  street A light code (green=00 yellow=01 left=10 red=11)
//   Lb     out 2  street B light code
//
// State map (q : La/Lb)
//   S0 000 A green          00/11    S4 100 B green          11/00
//   S1 001 A yellow-to-left 01/11    S5 101 B yellow-to-left 11/01
//   S2 010 A left           10/11    S6 110 B left           11/10
//   S3 011 A yellow         01/11    S7 111 B yellow         11/01
// -----------------------------------------------------------------------------
module tl_sequencer #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int LEFT_T    = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Tal,
    input  logic       Tbl,
    output logic [2:0] q,
    output logic [1:0] La,
    output logic [1:0] Lb
);

    typedef enum logic [2:0] {
        S0 = 3'b000,  // A green
        S1 = 3'b001,  // A yellow, heading to A left
        S2 = 3'b010,  // A left
        S3 = 3'b011,  // A yellow, heading to B green
        S4 = 3'b100,  // B green
        S5 = 3'b101,  // B yellow, heading to B left
        S6 = 3'b110,  // B left
        S7 = 3'b111   // B yellow, heading to A green
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_LEFT   = 2'b10;
    localparam logic [1:0] L_RED    = 2'b11;

    // Terminal dwell counts, sized to the counter so comparisons stay width-clean.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST = CNT_W'(LEFT_T - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lreq_a;
    logic             lreq_b;

    // Green-phase exit qualifiers. Once the minimum green has elapsed, the
    // phase ends when its own street is empty, or when it has run to the
    // maximum and the other street (through or left) is waiting.
    logic a_exit;
    logic b_exit;
    logic a_left_next;
    logic b_left_next;
    logic yel_done;
    logic left_done;
    logic cnt_sat;

    always_comb begin
        a_exit      = (cnt >= GMIN_LAST) &&
                      (!Ta || ((cnt == GMAX_LAST) && (Tb || Tbl)));
        b_exit      = (cnt >= GMIN_LAST) &&
                      (!Tb || ((cnt == GMAX_LAST) && (Ta || Tal)));
        // A request arriving in the very cycle of the exit still counts.
        a_left_next = lreq_a || Tal;
        b_left_next = lreq_b || Tbl;
        yel_done    = (cnt == YEL_LAST);
        left_done   = (cnt == LEFT_LAST);
        cnt_sat     = (cnt == GMAX_LAST);
    end

    // NOTE: all state lives in this one clocked block and is updated with
    // non-blocking assignments, so every right-hand side sees the pre-edge
    // value (e.g. the S2 clear of lreq_a uses the state before the edge).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S0;
            cnt    <= '0;
            lreq_a <= 1'b0;
            lreq_b <= 1'b0;
        end else begin
            // Left-request latches: the grant phase clear dominates the set, so
            // a request raised during its own left phase is dropped.
            lreq_a <= (state == S2) ? 1'b0 : (lreq_a || Tal);
            lreq_b <= (state == S6) ? 1'b0 : (lreq_b || Tbl);

            case (state)
                S0: begin
                    if (a_exit) begin
                        state <= a_left_next ? S1 : S3;
                        cnt   <= '0;
                    end else if (!cnt_sat) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S4: begin
                    if (b_exit) begin
                        state <= b_left_next ? S5 : S7;
                        cnt   <= '0;
                    end else if (!cnt_sat) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S1, S3, S5, S7: begin
                    if (yel_done) begin
                        unique case (state)
                            S1:      state <= S2;
                            S3:      state <= S4;
                            S5:      state <= S6;
                            default: state <= S0;
                        endcase
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S2, S6: begin
                    if (left_done) begin
                        state <= (state == S2) ? S3 : S7;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign q = state;

    // Light decode: MSB of q selects the street that may be non-red, so both
    // streets can never show non-red together.
    always_comb begin
        La = L_RED;
        Lb = L_RED;
        case (q)
            3'b000:  La = L_GREEN;
            3'b001:  La = L_YELLOW;
            3'b010:  La = L_LEFT;
            3'b011:  La = L_YELLOW;
            3'b100:  Lb = L_GREEN;
            3'b101:  Lb = L_YELLOW;
            3'b110:  Lb = L_LEFT;
            default: Lb = L_YELLOW;
        endcase
    end

endmodule

// File: tb/tb_tl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tl_sequencer
//
// Directed bench for tl_sequencer. Each stimulus step drives the sensors on a
// falling edge and queues the hand-derived phase expected after the following
// rising edge; an independent monitor pops and compares shortly after every
// rising edge. Asynchronous-reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_tl_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       Ta    = 1'b0;
    logic       Tb    = 1'b0;
    logic       Tal   = 1'b0;
    logic       Tbl   = 1'b0;
    logic [2:0] q;
    logic [1:0] La;
    logic [1:0] Lb;

    tl_sequencer #(
        .GREEN_MIN (4),
        .GREEN_MAX (10),
        .YELLOW_T  (2),
        .LEFT_T    (3),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Ta    (Ta),
        .Tb    (Tb),
        .Tal   (Tal),
        .Tbl   (Tbl),
        .q     (q),
        .La    (La),
        .Lb    (Lb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] q;
        bit         chk_lrb;
        logic       lrb;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   step_id = 0;

    // Expected {La, Lb} for each phase, straight from the state table.
    function automatic logic [3:0] lights(input logic [2:0] s);
        case (s)
            3'd0:    return 4'b00_11;
            3'd1:    return 4'b01_11;
            3'd2:    return 4'b10_11;
            3'd3:    return 4'b01_11;
            3'd4:    return 4'b11_00;
            3'd5:    return 4'b11_01;
            3'd6:    return 4'b11_10;
            default: return 4'b11_01;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of sensors (at a falling edge), queue the expected phase
    // after the next rising edge, then advance to the next falling edge.
    task automatic step(input logic ta, input logic tb, input logic tal, input logic tbl,
                        input logic [2:0] eq, input bit chk = 1'b0, input logic lrb = 1'b0);
        exp_t e;
        Ta  = ta;
        Tb  = tb;
        Tal = tal;
        Tbl = tbl;
        step_id++;
        e.q       = eq;
        e.chk_lrb = chk;
        e.lrb     = lrb;
        e.id      = step_id;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic ta, input logic tb, input logic tal,
                        input logic tbl, input logic [2:0] eq);
        for (int i = 0; i < n; i++) step(ta, tb, tal, tbl, eq);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);
    endtask

    // Monitor: compare the queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("v%0d_q", e.id), 32'(q), 32'(e.q));
                check($sformatf("v%0d_lights", e.id), 32'({La, Lb}), 32'(lights(e.q)));
                if (e.chk_lrb)
                    check($sformatf("v%0d_lreq_b", e.id), 32'(dut.lreq_b), 32'(e.lrb));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_q", 32'(q), 32'd0);
        check("rst_lights", 32'({La, Lb}), 32'b00_11);
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        check("rst_lreq", 32'({dut.lreq_a, dut.lreq_b}), 32'd0);
        reset = 1'b0;

        // A empty, B waiting: 4-cycle minimum green, 2-cycle yellow, B held.
        hold(3, 0, 1, 0, 0, 3'b000);
        hold(2, 0, 1, 0, 0, 3'b011);
        hold(7, 0, 1, 0, 0, 3'b100);

        // One-cycle Tal pulse during B green, then A returns through its left phase.
        step(0, 1, 1, 0, 3'b100);
        hold(2, 0, 0, 0, 0, 3'b111);
        hold(4, 0, 0, 0, 0, 3'b000);
        hold(2, 0, 0, 0, 0, 3'b001);
        hold(3, 0, 0, 0, 0, 3'b010);
        hold(2, 0, 0, 0, 0, 3'b011);
        step(1, 0, 0, 0, 3'b100);
        check("lreq_a_after_left", 32'(dut.lreq_a), 32'd0);

        // Back to A green via B yellow, no left requests pending.
        hold(3, 1, 0, 0, 0, 3'b100);
        hold(2, 1, 0, 0, 0, 3'b111);
        step(1, 1, 0, 0, 3'b000);

        // A busy, B waiting: A green lasts exactly GREEN_MAX cycles.
        hold(9, 1, 1, 0, 0, 3'b000);
        hold(2, 1, 1, 0, 0, 3'b011);
        step(1, 1, 0, 0, 3'b100);

        // Return to A green, then A busy with no B demand: stays in S0.
        hold(3, 1, 0, 0, 0, 3'b100);
        hold(2, 1, 0, 0, 0, 3'b111);
        hold(61, 1, 0, 0, 0, 3'b000);

        // Full B cycle with Tbl held: S5 2, S6 3 (lreq_b cleared), S7 2.
        hold(2, 0, 1, 0, 1, 3'b011);
        step(0, 1, 0, 1, 3'b100);
        hold(3, 0, 0, 0, 1, 3'b100);
        step(0, 0, 0, 1, 3'b101);
        step(0, 0, 0, 1, 3'b101, 1'b1, 1'b1);
        step(0, 0, 0, 1, 3'b110);
        step(0, 0, 0, 1, 3'b110, 1'b1, 1'b0);
        step(0, 0, 0, 1, 3'b110, 1'b1, 1'b0);
        hold(2, 0, 0, 0, 1, 3'b111);
        step(0, 0, 0, 1, 3'b000);

        // Walk into S6 again, with a Tal arriving during S6 so lreq_a is set.
        hold(3, 0, 1, 0, 0, 3'b000);
        hold(2, 0, 1, 0, 0, 3'b011);
        step(0, 1, 0, 0, 3'b100);
        hold(3, 0, 0, 0, 0, 3'b100);
        hold(2, 0, 0, 0, 0, 3'b101);
        step(0, 0, 0, 0, 3'b110);
        step(0, 0, 1, 0, 3'b110);
        drain();
        check("pre_rst_cnt", 32'(dut.cnt), 32'd1);
        check("pre_rst_lreq_a", 32'(dut.lreq_a), 32'd1);

        // Asynchronous reset mid-S6, checked before any clock edge.
        reset = 1'b1;
        Tal   = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'd0);
        check("async_rst_lights", 32'({La, Lb}), 32'b00_11);
        check("async_rst_cnt", 32'(dut.cnt), 32'd0);
        check("async_rst_lreq", 32'({dut.lreq_a, dut.lreq_b}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Dwell restarts from zero after release.
        hold(3, 0, 0, 0, 0, 3'b000);
        step(0, 0, 0, 0, 3'b011);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
